// File: rtl/pm_pkg.sv
// -----------------------------------------------------------------------------
// pm_pkg
// Shared definitions for the GF(2^233) point-multiplication subsystem: field
// and key widths used by the ladder engine and by the arbiter in front of it,
// and the arbiter's controller state encoding.
// -----------------------------------------------------------------------------
package pm_pkg;

  // Field element / projective coordinate width for GF(2^233).
  localparam int PM_N    = 233;
  // The scalar key spans the full field width.
  localparam int KEY_W   = PM_N;
  localparam int COORD_W = PM_N;

  typedef logic [COORD_W-1:0] pm_coord_t;
  typedef logic [KEY_W-1:0]   pm_key_t;

  // Arbiter controller states.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LAUNCH = 3'd1,
    ST_WAIT   = 3'd2,
    ST_RESP   = 3'd3,
    ST_ABORT  = 3'd4
  } pm_state_e;

endpackage : pm_pkg

// File: rtl/rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Combinational round-robin first-one finder. Searches req starting at bit
// ptr and wrapping modulo NREQ; returns the index of the first set bit.
//
// Ports
//   req    in  NREQ    request vector
//   ptr    in  IDX_W   search start position (must be < NREQ)
//   grant  out IDX_W   index of the first set bit at or after ptr (0 if none)
//   any    out 1       at least one request is set
// -----------------------------------------------------------------------------
module rr_pick #(
  parameter int NREQ = 4,
  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] grant,
  output logic             any
);

  // Rotating a doubled copy right by ptr puts the search start at bit 0, so a
  // plain lowest-set-bit search gives the round-robin distance from ptr.
  logic [2*NREQ-1:0] dbl;
  logic [NREQ-1:0]   rot;
  logic [IDX_W:0]    sum;

  always_comb begin
    dbl = {req, req} >> ptr;
    rot = dbl[NREQ-1:0];
    any = |req;
    sum = '0;
    // Descending scan so the lowest distance is the last assignment made.
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (rot[k]) begin
        sum = {1'b0, ptr} + (IDX_W+1)'(k);
      end
    end
    // ptr + distance can exceed NREQ-1 by at most NREQ-1; one subtract wraps it.
    if (sum >= (IDX_W+1)'(NREQ)) begin
      sum = sum - (IDX_W+1)'(NREQ);
    end
    grant = sum[IDX_W-1:0];
  end

endmodule : rr_pick

// File: rtl/pm_arbiter.sv
// -----------------------------------------------------------------------------
// pm_arbiter
// Round-robin scheduler sharing one Montgomery-ladder point-multiplication
// engine between NREQ requesters. One job is in flight at a time: the chosen
// requester's operands are latched, the engine is started with a one-cycle
// pulse, and the result is held on the shared response bus until the granted
// requester acknowledges. A watchdog resets the engine and returns an error
// response if the engine does not finish within TIMEOUT cycles.
//
// Ports
//   CLK, RST_N                clock, synchronous active-low reset
//   req_valid   in  NREQ      per-requester job request
//   req_ready   out NREQ      one-hot accept strobe (combinational)
//   req_x/y/z/key in NREQ*N   flattened operands, slice i = [i*N +: N]
//   rsp_valid   out NREQ      one-hot result valid (combinational), held to ack
//   rsp_ready   in  NREQ      per-requester result acknowledge
//   rsp_x/y     out N         shared result bus
//   rsp_err     out 1         result is a timeout abort (rsp_x = rsp_y = 0)
//   busy        out 1         controller not idle
//   pm_rst_n    out 1         engine reset, low for one cycle on reset/timeout
//   pm_in_valid out 1         engine start pulse
//   pm_x/y/z/key out N        latched operands for the engine
//   pm_out_valid in 1         engine done pulse
//   pm_dout_x/y in  N         engine result
// -----------------------------------------------------------------------------
module pm_arbiter
  import pm_pkg::*;
#(
  parameter int               N       = PM_N,
  parameter int               NREQ    = 4,
  parameter int               TMO_W   = 20,
  parameter logic [TMO_W-1:0] TIMEOUT = {TMO_W{1'b1}}
) (
  input  logic                CLK,
  input  logic                RST_N,
  input  logic [NREQ-1:0]     req_valid,
  output logic [NREQ-1:0]     req_ready,
  input  logic [NREQ*N-1:0]   req_x,
  input  logic [NREQ*N-1:0]   req_y,
  input  logic [NREQ*N-1:0]   req_z,
  input  logic [NREQ*N-1:0]   req_key,
  output logic [NREQ-1:0]     rsp_valid,
  input  logic [NREQ-1:0]     rsp_ready,
  output logic [N-1:0]        rsp_x,
  output logic [N-1:0]        rsp_y,
  output logic                rsp_err,
  output logic                busy,
  output logic                pm_rst_n,
  output logic                pm_in_valid,
  output logic [N-1:0]        pm_x,
  output logic [N-1:0]        pm_y,
  output logic [N-1:0]        pm_z,
  output logic [N-1:0]        pm_key,
  input  logic                pm_out_valid,
  input  logic [N-1:0]        pm_dout_x,
  input  logic [N-1:0]        pm_dout_y
);

  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  // The watchdog fires on the last count value of the WAIT window.
  localparam logic [TMO_W-1:0] TMO_LAST = TIMEOUT - TMO_W'(1);

  pm_state_e         state_q, state_d;
  logic [IDX_W-1:0]  grant_q, grant_d;
  logic [IDX_W-1:0]  ptr_q, ptr_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic [N-1:0]      pm_x_q, pm_x_d;
  logic [N-1:0]      pm_y_q, pm_y_d;
  logic [N-1:0]      pm_z_q, pm_z_d;
  logic [N-1:0]      pm_key_q, pm_key_d;
  logic [N-1:0]      rsp_x_q, rsp_x_d;
  logic [N-1:0]      rsp_y_q, rsp_y_d;
  logic              rsp_err_q, rsp_err_d;
  logic              busy_q, busy_d;
  logic              pm_in_valid_q, pm_in_valid_d;
  logic              pm_rst_n_q, pm_rst_n_d;

  logic [IDX_W-1:0]  pick_idx;
  logic              pick_any;
  logic              ack;

  rr_pick #(
    .NREQ (NREQ)
  ) u_rr_pick (
    .req   (req_valid),
    .ptr   (ptr_q),
    .grant (pick_idx),
    .any   (pick_any)
  );

  // Accept and response strobes decode straight from state and grant so a
  // requester sees them in the same cycle the controller acts. req_ready is
  // held low while reset is asserted so nothing looks accepted during reset.
  always_comb begin
    req_ready = '0;
    if (RST_N && (state_q == ST_IDLE) && pick_any) begin
      req_ready = NREQ'(1) << pick_idx;
    end
    rsp_valid = '0;
    if (state_q == ST_RESP) begin
      rsp_valid = NREQ'(1) << grant_q;
    end
  end

  // Only the granted requester's acknowledge counts; others are masked.
  assign ack = |(rsp_ready & rsp_valid);

  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    ptr_d         = ptr_q;
    tmo_d         = tmo_q;
    pm_x_d        = pm_x_q;
    pm_y_d        = pm_y_q;
    pm_z_d        = pm_z_q;
    pm_key_d      = pm_key_q;
    rsp_x_d       = rsp_x_q;
    rsp_y_d       = rsp_y_q;
    rsp_err_d     = rsp_err_q;
    pm_in_valid_d = 1'b0;
    pm_rst_n_d    = 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          grant_d = pick_idx;
          // Operand mux written as a constant-index loop over requesters.
          for (int i = 0; i < NREQ; i++) begin
            if (pick_idx == IDX_W'(i)) begin
              pm_x_d   = req_x[i*N +: N];
              pm_y_d   = req_y[i*N +: N];
              pm_z_d   = req_z[i*N +: N];
              pm_key_d = req_key[i*N +: N];
            end
          end
          // Start pulse is registered so it appears in the LAUNCH cycle.
          pm_in_valid_d = 1'b1;
          state_d       = ST_LAUNCH;
        end
      end

      ST_LAUNCH: begin
        tmo_d   = '0;
        state_d = ST_WAIT;
      end

      ST_WAIT: begin
        tmo_d = tmo_q + TMO_W'(1);
        // Completion takes priority over a watchdog expiry in the same cycle.
        if (pm_out_valid) begin
          rsp_x_d   = pm_dout_x;
          rsp_y_d   = pm_dout_y;
          rsp_err_d = 1'b0;
          state_d   = ST_RESP;
        end else if (tmo_q == TMO_LAST) begin
          // Engine reset is registered so it is low exactly in the ABORT cycle.
          pm_rst_n_d = 1'b0;
          state_d    = ST_ABORT;
        end
      end

      ST_ABORT: begin
        rsp_x_d   = '0;
        rsp_y_d   = '0;
        rsp_err_d = 1'b1;
        state_d   = ST_RESP;
      end

      ST_RESP: begin
        if (ack) begin
          ptr_d   = (grant_q == IDX_W'(NREQ - 1)) ? '0 : grant_q + IDX_W'(1);
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q       <= ST_IDLE;
      grant_q       <= '0;
      ptr_q         <= '0;
      tmo_q         <= '0;
      pm_x_q        <= '0;
      pm_y_q        <= '0;
      pm_z_q        <= '0;
      pm_key_q      <= '0;
      rsp_x_q       <= '0;
      rsp_y_q       <= '0;
      rsp_err_q     <= 1'b0;
      busy_q        <= 1'b0;
      pm_in_valid_q <= 1'b0;
      pm_rst_n_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      ptr_q         <= ptr_d;
      tmo_q         <= tmo_d;
      pm_x_q        <= pm_x_d;
      pm_y_q        <= pm_y_d;
      pm_z_q        <= pm_z_d;
      pm_key_q      <= pm_key_d;
      rsp_x_q       <= rsp_x_d;
      rsp_y_q       <= rsp_y_d;
      rsp_err_q     <= rsp_err_d;
      busy_q        <= busy_d;
      pm_in_valid_q <= pm_in_valid_d;
      pm_rst_n_q    <= pm_rst_n_d;
    end
  end

  assign rsp_x       = rsp_x_q;
  assign rsp_y       = rsp_y_q;
  assign rsp_err     = rsp_err_q;
  assign busy        = busy_q;
  assign pm_rst_n    = pm_rst_n_q;
  assign pm_in_valid = pm_in_valid_q;
  assign pm_x        = pm_x_q;
  assign pm_y        = pm_y_q;
  assign pm_z        = pm_z_q;
  assign pm_key      = pm_key_q;

endmodule : pm_arbiter

// File: tb/tb_pm_arbiter.sv
// -----------------------------------------------------------------------------
// tb_pm_arbiter
// Self-checking bench for pm_arbiter. A transaction-level reference predicts
// the grant order, response cycle and response contents of each job from the
// requesters' operands, the engine latency chosen for the job and the
// round-robin rule. A small engine model answers start pulses.
// -----------------------------------------------------------------------------
module tb_pm_arbiter;

  localparam int N     = 233;
  localparam int NREQ  = 4;
  localparam int TMO_W = 20;
  localparam int TMO   = 16;
  localparam int NEVER = 1000;

  logic                CLK = 1'b0;
  logic                RST_N;
  logic [NREQ-1:0]     req_valid, req_ready, rsp_valid, rsp_ready;
  logic [NREQ*N-1:0]   req_x, req_y, req_z, req_key;
  logic [N-1:0]        rsp_x, rsp_y, pm_x, pm_y, pm_z, pm_key;
  logic [N-1:0]        pm_dout_x, pm_dout_y;
  logic                rsp_err, busy, pm_rst_n, pm_in_valid, pm_out_valid;

  pm_arbiter #(
    .N       (N),
    .NREQ    (NREQ),
    .TMO_W   (TMO_W),
    .TIMEOUT (TMO_W'(TMO))
  ) dut (
    .CLK          (CLK),
    .RST_N        (RST_N),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_x        (req_x),
    .req_y        (req_y),
    .req_z        (req_z),
    .req_key      (req_key),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_x        (rsp_x),
    .rsp_y        (rsp_y),
    .rsp_err      (rsp_err),
    .busy         (busy),
    .pm_rst_n     (pm_rst_n),
    .pm_in_valid  (pm_in_valid),
    .pm_x         (pm_x),
    .pm_y         (pm_y),
    .pm_z         (pm_z),
    .pm_key       (pm_key),
    .pm_out_valid (pm_out_valid),
    .pm_dout_x    (pm_dout_x),
    .pm_dout_y    (pm_dout_y)
  );

  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  // Engine model state.
  int         done_cyc  = -1;
  int         eng_lat   = 5;
  bit         eng_fixed = 1'b0;
  logic [N-1:0] eng_rx = '0, eng_ry = '0;

  // Reference model state.
  logic [N-1:0]    op_x[NREQ], op_y[NREQ], op_z[NREQ], op_k[NREQ];
  logic [NREQ-1:0] pend = '0;
  int              m_ptr = 0;
  logic [N-1:0]    last_x = '0, last_y = '0;
  logic            last_err = 1'b0;

  task automatic chk(input string tag, input logic [N-1:0] got, input logic [N-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  function automatic logic [N-1:0] rand_n();
    logic [255:0] t;
    for (int i = 0; i < 8; i++) t[i*32 +: 32] = $urandom;
    return t[N-1:0];
  endfunction

  function automatic int pick(input logic [NREQ-1:0] p, input int ptr);
    for (int k = 0; k < NREQ; k++) begin
      if (p[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
    end
    return -1;
  endfunction

  task automatic put_ops(input int i);
    req_x[i*N +: N]   = op_x[i];
    req_y[i*N +: N]   = op_y[i];
    req_z[i*N +: N]   = op_z[i];
    req_key[i*N +: N] = op_k[i];
  endtask

  task automatic raise_ops(input int i, input logic [N-1:0] x, input logic [N-1:0] y,
                           input logic [N-1:0] z, input logic [N-1:0] k);
    op_x[i] = x; op_y[i] = y; op_z[i] = z; op_k[i] = k;
    pend[i] = 1'b1;
    put_ops(i);
  endtask

  task automatic raise(input int i);
    if (!pend[i]) raise_ops(i, rand_n(), rand_n(), rand_n(), rand_n());
  endtask

  // A requester that is not asking drives garbage operands.
  task automatic drop(input int i);
    pend[i] = 1'b0;
    req_x[i*N +: N]   = rand_n();
    req_y[i*N +: N]   = rand_n();
    req_z[i*N +: N]   = rand_n();
    req_key[i*N +: N] = rand_n();
  endtask

  task automatic drive_reqs();
    req_valid = pend;
  endtask

  // Advance one cycle; outputs are sampled 1 time unit after the edge and the
  // engine model decides its done pulse for the new cycle.
  task automatic tick();
    @(posedge CLK);
    #1;
    cyc++;
    if (!pm_rst_n) begin
      done_cyc = -1;
    end else if (pm_in_valid) begin
      done_cyc = (eng_lat >= NEVER) ? -1 : cyc + eng_lat;
      eng_rx   = eng_fixed ? N'('hAA) : (pm_x ^ pm_key);
      eng_ry   = eng_fixed ? N'('hBB) : (pm_y ^ pm_z);
    end
    pm_out_valid = (done_cyc == cyc);
    pm_dout_x    = pm_out_valid ? eng_rx : rand_n();
    pm_dout_y    = pm_out_valid ? eng_ry : rand_n();
  endtask

  // One complete job starting in a cycle where the arbiter is idle.
  task automatic run_job(input int lat, input int ack_dly, input bit fixed,
                         input logic [NREQ-1:0] add, input bit noise);
    int g, t0, e;
    logic [N-1:0] gx, gy, gz, gk, ex, ey;
    logic ee;
    drive_reqs();
    #1;
    g = pick(pend, m_ptr);
    if (g < 0) begin
      n_cmp++; n_bad++;
      $display("FAIL no_request @cyc %0d: got none expected a pending request", cyc);
      return;
    end
    gx = op_x[g]; gy = op_y[g]; gz = op_z[g]; gk = op_k[g];
    if (lat <= TMO) begin
      ex = fixed ? N'('hAA) : (gx ^ gk);
      ey = fixed ? N'('hBB) : (gy ^ gz);
      ee = 1'b0;
      e  = lat + 2;
    end else begin
      ex = '0; ey = '0; ee = 1'b1;
      e  = TMO + 3;
    end
    chk("req_ready", req_ready, NREQ'(1) << g);
    chk("busy_idle", busy, 1'b0);
    eng_lat = lat; eng_fixed = fixed;
    t0 = cyc;

    tick();
    drop(g);
    for (int i = 0; i < NREQ; i++) if (add[i]) raise(i);
    drive_reqs();
    chk("pm_in_valid", pm_in_valid, 1'b1);
    chk("pm_rst_n_launch", pm_rst_n, 1'b1);
    chk("pm_x", pm_x, gx);
    chk("pm_y", pm_y, gy);
    chk("pm_z", pm_z, gz);
    chk("pm_key", pm_key, gk);
    chk("busy_launch", busy, 1'b1);
    #1;
    chk("req_ready_launch", req_ready, '0);

    while (cyc < t0 + e - 1) begin
      tick();
      if (noise && $urandom_range(0, 3) == 0) raise($urandom_range(0, NREQ - 1));
      drive_reqs();
      chk("pm_in_valid_wait", pm_in_valid, 1'b0);
      chk("pm_rst_n_wait", pm_rst_n, (ee && cyc == t0 + 2 + TMO) ? 1'b0 : 1'b1);
      chk("busy_wait", busy, 1'b1);
      #1;
      chk("rsp_valid_wait", rsp_valid, '0);
      chk("req_ready_wait", req_ready, '0);
    end

    tick();
    chk("rsp_x", rsp_x, ex);
    chk("rsp_y", rsp_y, ey);
    chk("rsp_err", rsp_err, ee);
    chk("busy_resp", busy, 1'b1);
    chk("pm_rst_n_resp", pm_rst_n, 1'b1);
    chk("pm_x_hold", pm_x, gx);
    for (int a = 0; a < ack_dly; a++) begin
      rsp_ready = NREQ'($urandom) & ~(NREQ'(1) << g);
      if (noise && $urandom_range(0, 2) == 0) pm_out_valid = 1'b1;
      #1;
      chk("rsp_valid", rsp_valid, NREQ'(1) << g);
      chk("req_ready_resp", req_ready, '0);
      tick();
      chk("rsp_x_hold", rsp_x, ex);
      chk("rsp_y_hold", rsp_y, ey);
      chk("rsp_err_hold", rsp_err, ee);
      chk("busy_hold", busy, 1'b1);
    end
    rsp_ready = NREQ'($urandom) | (NREQ'(1) << g);
    #1;
    chk("rsp_valid_ack", rsp_valid, NREQ'(1) << g);
    tick();
    rsp_ready = '0;
    m_ptr = (g + 1) % NREQ;
    last_x = ex; last_y = ey; last_err = ee;
    chk("busy_after", busy, 1'b0);
    #1;
    chk("rsp_valid_after", rsp_valid, '0);
  endtask

  // Idle cycles with stray engine done pulses; nothing may change.
  task automatic idle_stray(input int n);
    repeat (n) begin
      pm_out_valid = 1'b1;
      #1;
      chk("req_ready_idle", req_ready, '0);
      tick();
      chk("rsp_x_idle", rsp_x, last_x);
      chk("rsp_y_idle", rsp_y, last_y);
      chk("rsp_err_idle", rsp_err, last_err);
      chk("busy_idle_stray", busy, 1'b0);
    end
  endtask

  initial begin
    int g, r, lat;
    RST_N = 1'b0;
    rsp_ready = '0;
    pm_out_valid = 1'b0;
    pm_dout_x = '0;
    pm_dout_y = '0;
    for (int i = 0; i < NREQ; i++) drop(i);
    // All four requesters wait through reset.
    for (int i = 0; i < NREQ; i++) raise(i);
    drive_reqs();
    repeat (3) tick();
    chk("rst_busy", busy, 1'b0);
    chk("rst_rsp_x", rsp_x, '0);
    chk("rst_rsp_y", rsp_y, '0);
    chk("rst_rsp_err", rsp_err, 1'b0);
    chk("rst_pm_in_valid", pm_in_valid, 1'b0);
    chk("rst_pm_rst_n", pm_rst_n, 1'b0);
    chk("rst_pm_x", pm_x, '0);
    chk("rst_pm_key", pm_key, '0);
    #1;
    chk("rst_req_ready", req_ready, '0);
    chk("rst_rsp_valid", rsp_valid, '0);
    RST_N = 1'b1;

    // Grants 0,1,2,3 with instant acknowledge, then 1 and 3 only.
    for (int j = 0; j < NREQ; j++) run_job(3, 0, 1'b0, '0, 1'b0);
    raise(1); raise(3);
    run_job(2, 0, 1'b0, '0, 1'b0);
    run_job(2, 0, 1'b0, '0, 1'b0);

    // Single known job on requester 0, engine done after 10 cycles.
    raise_ops(0, N'(1), N'(2), N'(3), N'(5));
    run_job(10, 2, 1'b1, '0, 1'b0);

    // Timeout abort, then a normal job; then completion on the expiry cycle.
    raise(2);
    run_job(NEVER, 1, 1'b0, '0, 1'b0);
    raise(0);
    run_job(6, 0, 1'b0, '0, 1'b0);
    raise(3);
    run_job(TMO, 1, 1'b0, '0, 1'b0);

    // Backpressure: requester 2 waits while the response is held 50 cycles.
    raise(1);
    run_job(4, 50, 1'b0, 4'b0100, 1'b0);
    run_job(3, 0, 1'b0, '0, 1'b0);
    idle_stray(4);

    // Reset during WAIT drops the job; the request is then granted afresh.
    raise(1); raise(3);
    drive_reqs();
    #1;
    g = pick(pend, m_ptr);
    eng_lat = NEVER;
    tick();
    drop(g);
    drive_reqs();
    repeat (5) tick();
    RST_N = 1'b0;
    tick();
    chk("wrst_busy", busy, 1'b0);
    chk("wrst_pm_rst_n", pm_rst_n, 1'b0);
    chk("wrst_pm_in_valid", pm_in_valid, 1'b0);
    chk("wrst_pm_x", pm_x, '0);
    chk("wrst_rsp_x", rsp_x, '0);
    chk("wrst_rsp_err", rsp_err, 1'b0);
    #1;
    chk("wrst_rsp_valid", rsp_valid, '0);
    chk("wrst_req_ready", req_ready, '0);
    RST_N = 1'b1;
    m_ptr = 0;
    last_x = '0; last_y = '0; last_err = 1'b0;
    raise(g);
    run_job(5, 1, 1'b0, '0, 1'b0);
    while (pend != '0) run_job(2, 0, 1'b0, '0, 1'b0);

    // Randomized traffic.
    for (int j = 0; j < 150; j++) begin
      if (pend == '0 || $urandom_range(0, 1) == 1) raise($urandom_range(0, NREQ - 1));
      if ($urandom_range(0, 2) == 0) raise($urandom_range(0, NREQ - 1));
      r = $urandom_range(0, 9);
      if (r == 0)      lat = NEVER;
      else if (r == 1) lat = TMO;
      else             lat = $urandom_range(1, TMO - 1);
      run_job(lat, $urandom_range(0, 4), 1'b0, '0, 1'b1);
      if (pend == '0 && $urandom_range(0, 3) == 0) idle_stray(2);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no end of test, expected finish within time limit");
    $fatal(1, "time limit");
  end

endmodule : tb_pm_arbiter
